// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry,
// LSB first, start/busy/done handshake and signed-overflow detection.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             s_bit, c_next, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
        c_next  = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
        last    = (cnt_q == LAST);
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && start) begin
            // Subtraction is a + ~b + 1; borrow-in folds into the inverted carry.
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = cin ^ sub;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == RUN) begin
            opa_d          = opa_q >> 1;
            opb_d          = opb_q >> 1;
            carry_d        = c_next;
            res_d          = res_q >> 1;
            res_d[WIDTH-1] = s_bit;
            cnt_d          = cnt_q + 1'b1;
            if (last) begin
                // carry_q here is the carry into the MSB cell.
                sum_d  = res_d;
                cout_d = c_next;
                ovf_d  = carry_q ^ c_next;
            end
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        sum      = sum_q;
        cout     = cout_q;
        overflow = ovf_q;
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 4 and 1 against an integer
// arithmetic model.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cin = 1'b0, sub = 1'b0;
    logic       start8 = 1'b0, start4 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       a1 = 1'b0, b1 = 1'b0, sum1;
    logic       busy8, done8, cout8, ovf8;
    logic       busy4, done4, cout4, ovf4;
    logic       busy1, done1, cout1, ovf1;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .cin(cin), .sub(sub), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));
    serial_adder #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .cin(cin), .sub(sub), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4));
    serial_adder #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .cin(cin), .sub(sub), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

    // {overflow, cout, sum zero-extended to 8 bits}
    function automatic logic [9:0] mdl(input int w, input logic [7:0] av, input logic [7:0] bv,
                                       input logic ci, input logic sb);
        logic [8:0] mask, aa, bb, t;
        logic [7:0] s;
        logic       co, ov;
        mask = (9'd1 << w) - 9'd1;
        aa   = {1'b0, av} & mask;
        bb   = (sb ? {1'b0, ~bv} : {1'b0, bv}) & mask;
        t    = aa + bb + {8'd0, ci ^ sb};
        co   = t[w];
        s    = t[7:0] & mask[7:0];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    function automatic logic dn(input int w);
        return (w == 8) ? done8 : (w == 4) ? done4 : done1;
    endfunction

    function automatic logic bz(input int w);
        return (w == 8) ? busy8 : (w == 4) ? busy4 : busy1;
    endfunction

    function automatic logic [9:0] res(input int w);
        if (w == 8) return {ovf8, cout8, sum8};
        if (w == 4) return {ovf4, cout4, 4'd0, sum4};
        return {ovf1, cout1, 7'd0, sum1};
    endfunction

    // Drive one request, push its expected result, return just after the accept edge.
    task automatic issue(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic sb);
        cin = ci;
        sub = sb;
        case (w)
            8: begin a8 = av; b8 = bv; start8 = 1'b1; end
            4: begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
            default: begin a1 = av[0]; b1 = bv[0]; start1 = 1'b1; end
        endcase
        exp_q.push_back(mdl(w, av, bv, ci, sb));
        @(posedge clk); #1;
        start8 = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
    endtask

    // Bounded wait for done; captures the result and whether done/busy drop on the next edge.
    task automatic wait_done(input int w, input int limit, output bit got, output int cyc,
                             output logic [9:0] r, output bit pulse1);
        got = 1'b0;
        cyc = 0;
        r = 'x;
        pulse1 = 1'b0;
        while (cyc < limit && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (dn(w)) got = 1'b1;
        end
        if (got) begin
            r = res(w);
            @(posedge clk); #1;
            pulse1 = !dn(w) && !bz(w);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8, busy4, done4, sum4, cout4, ovf4,
             busy1, done1, sum1, cout1, ovf1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: w8 %b%b %h w4 %b%b %h w1 %b%b %h, need all zero",
                     busy8, done8, sum8, busy4, done4, sum4, busy1, done1, sum1);
        end
    endtask

    task automatic test_latency();
        bit got, p;
        int cyc;
        logic [9:0] r, e;
        issue(8, 8'h0F, 8'h01, 1'b0, 1'b0);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: got %b need 1", busy8);
        end
        wait_done(8, 20, got, cyc, r, p);
        e = exp_q.pop_front();
        checks++;
        if (!got || r !== e || cyc != 8 || !p) begin
            errors++;
            $display("FAIL latency_0f_01: got %b res %h cyc %0d pulse %b, need res %h cyc 8 pulse 1",
                     got, r, cyc, p, e);
        end
    endtask

    task automatic test_arith();
        logic [7:0] ta[6] = '{8'hFF, 8'h7F, 8'h10, 8'h05, 8'h80, 8'h10};
        logic [7:0] tb[6] = '{8'h01, 8'h01, 8'h20, 8'h07, 8'h01, 8'h01};
        logic       tc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [9:0] lit[6] = '{10'h100, 10'h280, 10'h031, 10'h0FE, 10'h37F, 10'h10E};
        bit got, p;
        int cyc;
        logic [9:0] r, e;
        for (int i = 0; i < 6; i++) begin
            issue(8, ta[i], tb[i], tc[i], ts[i]);
            wait_done(8, 20, got, cyc, r, p);
            e = exp_q.pop_front();
            checks++;
            if (!got || r !== e || r !== lit[i]) begin
                errors++;
                $display("FAIL arith_%0d: got %b res %h, need %h", i, got, r, lit[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit got, p, stable;
        int cyc;
        logic [9:0] r, e;
        issue(8, 8'h12, 8'h34, 1'b0, 1'b0);
        // Hold start with different operands while busy: must be ignored.
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1; sub = 1'b1;
        wait_done(8, 20, got, cyc, r, p);
        start8 = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!got || r !== e || r !== 10'h046) begin
            errors++;
            $display("FAIL hold_ignored: got %b res %h, need 046", got, r);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: busy %b need 0", busy8);
        end
        issue(8, 8'hA5, 8'h5A, 1'b1, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if ({ovf8, cout8, sum8} !== 10'h046 || done8) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL stable_between_dones: got %h done %b, need 046 done 0",
                     {ovf8, cout8, sum8}, done8);
        end
        wait_done(8, 5, got, cyc, r, p);
        e = exp_q.pop_front();
        checks++;
        if (!got || r !== e || cyc != 1) begin
            errors++;
            $display("FAIL back_to_back: got %b res %h cyc %0d, need %h cyc 1", got, r, cyc, e);
        end
    endtask

    task automatic test_reset_mid_run();
        bit got, p, seen;
        int cyc;
        logic [9:0] r, e;
        issue(8, 8'h0F, 8'h01, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== '0) begin
            errors++;
            $display("FAIL reset_abort: busy %b done %b sum %h cout %b ovf %b, need all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done8 || busy8) seen = 1'b1; end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL no_done_after_abort: activity seen %b need 0", seen);
        end
        issue(8, 8'hC3, 8'h3D, 1'b0, 1'b1);
        wait_done(8, 20, got, cyc, r, p);
        e = exp_q.pop_front();
        checks++;
        if (!got || r !== e) begin
            errors++;
            $display("FAIL op_after_reset: got %b res %h, need %h", got, r, e);
        end
    endtask

    task automatic test_exhaustive(input int w);
        bit got, p;
        int cyc, n;
        logic [9:0] r, e;
        n = 1 << w;
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < n; j++) begin
                        issue(w, 8'(i), 8'(j), c[0], s[0]);
                        wait_done(w, w + 6, got, cyc, r, p);
                        e = exp_q.pop_front();
                        checks++;
                        if (!got || r !== e || cyc != w || !p) begin
                            errors++;
                            $display("FAIL exh_w%0d a=%0d b=%0d cin=%0d sub=%0d: res %h cyc %0d, need %h cyc %0d",
                                     w, i, j, c, s, r, cyc, e, w);
                        end
                    end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_latency();
        test_arith();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive(1);
        test_exhaustive(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
